// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit producing HI:LO.
// Multiply is radix-2 Booth over 32 cycles; divide is restoring on magnitudes plus a sign-fix cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FIX} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;       // multiplicand, or |divisor|
    logic [W-1:0]    acc_q, acc_d;   // Booth upper half, or partial remainder
    logic [W-1:0]    p_q, p_d;       // Booth lower half, or quotient
    logic            qm1_q, qm1_d;
    logic            sa_q, sa_d, sb_q, sb_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic            busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic            last_iter_c;
    logic [W:0]      booth_sum_c;
    logic [W:0]      rem_sh_c;
    logic [W-1:0]    quo_sh_c;
    logic [W-1:0]    trial_c;
    logic            rem_ge_c;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? W'(0) - x : x;
    endfunction

    assign last_iter_c = (cnt_q == CW'(W - 1));
    assign rem_sh_c    = {acc_q, p_q[W-1]};
    assign quo_sh_c    = {p_q[W-2:0], 1'b0};
    assign rem_ge_c    = (rem_sh_c >= {1'b0, a_q});
    assign trial_c     = rem_sh_c[W-1:0] - a_q;

    // 33-bit Booth add/sub keeps the sign of the upper half intact
    always_comb begin
        case ({p_q[0], qm1_q})
            2'b01:   booth_sum_c = {acc_q[W-1], acc_q} + {a_q[W-1], a_q};
            2'b10:   booth_sum_c = {acc_q[W-1], acc_q} - {a_q[W-1], a_q};
            default: booth_sum_c = {acc_q[W-1], acc_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_mult)                     state_d = S_MULT;
                else if (start_div && b_in != '0)   state_d = S_DIV;
            end
            S_MULT:  if (last_iter_c) state_d = S_IDLE;
            S_DIV:   if (last_iter_c) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        acc_d  = acc_q;
        p_d    = p_q;
        qm1_d  = qm1_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        done_d = 1'b0;
        dz_d   = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start_mult) begin
                    a_d    = a_in;
                    p_d    = b_in;
                    acc_d  = '0;
                    qm1_d  = 1'b0;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    busy_d = 1'b1;
                end else if (start_div) begin
                    if (b_in == '0) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        sa_d   = a_in[W-1];
                        sb_d   = b_in[W-1];
                        a_d    = mag(b_in);
                        p_d    = mag(a_in);
                        acc_d  = '0;
                        qm1_d  = 1'b0;
                        cnt_d  = '0;
                        dz_d   = 1'b0;
                        busy_d = 1'b1;
                    end
                end
            end
            S_MULT: begin
                acc_d = booth_sum_c[W:1];
                p_d   = {booth_sum_c[0], p_q[W-1:1]};
                qm1_d = p_q[0];
                cnt_d = cnt_q + CW'(1);
                if (last_iter_c) begin
                    hi_d   = booth_sum_c[W:1];
                    lo_d   = {booth_sum_c[0], p_q[W-1:1]};
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_DIV: begin
                if (rem_ge_c) begin
                    acc_d = trial_c;
                    p_d   = {quo_sh_c[W-1:1], 1'b1};
                end else begin
                    acc_d = rem_sh_c[W-1:0];
                    p_d   = quo_sh_c;
                end
                cnt_d = cnt_q + CW'(1);
            end
            S_FIX: begin
                lo_d   = (sa_q ^ sb_q) ? W'(0) - p_q : p_q;
                hi_d   = sa_q ? W'(0) - acc_q : acc_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            acc_q  <= '0;
            p_q    <= '0;
            qm1_q  <= 1'b0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            acc_q  <= acc_d;
            p_q    <= p_d;
            qm1_q  <= qm1_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences,
// and random operations checked against a plain-arithmetic reference.
module tb_mult_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;

    mult_div_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic, C-style truncating division
    function automatic void model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi_e, output logic [31:0] lo_e);
        longint sa;
        longint sb;
        longint r64;
        longint q64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (mult) begin
            r64  = sa * sb;
            hi_e = r64[63:32];
            lo_e = r64[31:0];
        end else begin
            q64  = sa / sb;
            r64  = sa % sb;
            hi_e = r64[31:0];
            lo_e = q64[31:0];
        end
    endfunction

    // Called at a negedge; returns at the sample where done is seen.
    task automatic do_op(input string tag, input bit mult, input bit both, input int inject,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        int busy_bad;
        start_mult = mult | both;
        start_div  = !mult | both;
        a_in       = a;
        b_in       = b;
        @(negedge clk);
        k        = 0;
        busy_bad = 0;
        while (!done && k < 100) begin
            if (!busy) busy_bad++;
            start_mult = 1'b0;
            start_div  = (k == inject);
            a_in       = $urandom;
            b_in       = $urandom;
            @(negedge clk);
            k++;
        end
        start_div = 1'b0;
        check({tag, " latency"}, 64'(k), (mult | both) ? 64'd32 : 64'd33);
        check({tag, " busy_hold"}, 64'(busy_bad), 64'd0);
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        check({tag, " div_zero"}, 64'(div_zero), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rm;

        vecs[0] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[3] = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022};

        reset_n    = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vecs[i].mult, 1'b0, -1,
                  vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Divide by zero right after HI=0x11, LO=0x22
        start_div = 1'b1;
        a_in      = 32'd5;
        b_in      = 32'd0;
        @(negedge clk);
        start_div = 1'b0;
        check("dz done", 64'(done), 64'd1);
        check("dz flag", 64'(div_zero), 64'd1);
        check("dz busy", 64'(busy), 64'd0);
        check("dz hi", 64'(hi), 64'h11);
        check("dz lo", 64'(lo), 64'h22);
        @(negedge clk);
        check("dz done_pulse", 64'(done), 64'd0);
        check("dz flag_hold", 64'(div_zero), 64'd1);
        check("dz busy_after", 64'(busy), 64'd0);

        ra = $urandom;
        rb = $urandom;
        model(1'b1, ra, rb, eh, el);
        do_op("after_dz", 1'b1, 1'b0, -1, ra, rb, eh, el);

        // Start pulse during a running multiply is ignored
        ra = $urandom;
        rb = $urandom;
        model(1'b1, ra, rb, eh, el);
        do_op("inject", 1'b1, 1'b0, 5, ra, rb, eh, el);

        // Simultaneous starts run the multiply only
        ra = 32'hFFFF_FF00;
        rb = 32'h0000_0123;
        model(1'b1, ra, rb, eh, el);
        do_op("both", 1'b1, 1'b1, -1, ra, rb, eh, el);

        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            if (i % 3 == 0) begin
                rb = 32'($urandom_range(1, 1000));
                if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
            end else begin
                rb = $urandom;
            end
            if (rb == '0) rb = 32'd1;
            model(rm, ra, rb, eh, el);
            do_op($sformatf("rnd%0d", i), rm, 1'b0, -1, ra, rb, eh, el);
        end

        // Reset in the middle of a divide
        start_div = 1'b1;
        a_in      = 32'd100;
        b_in      = 32'd7;
        @(negedge clk);
        start_div = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst hi", 64'(hi), 64'd0);
        check("mid_rst lo", 64'(lo), 64'd0);
        check("mid_rst busy", 64'(busy), 64'd0);
        check("mid_rst done", 64'(done), 64'd0);
        check("mid_rst div_zero", 64'(div_zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst busy", 64'(busy), 64'd0);
        check("post_rst done", 64'(done), 64'd0);
        check("post_rst lo", 64'(lo), 64'd0);
        do_op("mul3x4", 1'b1, 1'b0, -1, 32'd3, 32'd4, 32'd0, 32'd12);

        @(negedge clk);
        check("final done_pulse", 64'(done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
